mem_stage_ctrl: RTL and testbench

Memory-stage controller on the consumer side of the EX/MEM buffer. It runs the data-memory transaction each instruction needs: single-word load/store, 2-beat PC push/pop, or 3-beat PC+flags push/pop. It talks to a variable-latency data memory through a req/ack handshake and freezes the upstream pipeline with a stall signal while it works. It produces registered MEM/WB writeback, PC-reload and flag-restore (Flags_From_Memory) outputs.

---
 rtl/mem_stage_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: runs 1/2/3-beat data-memory transactions over a req/ack
// handshake, stalls upstream while busy, and registers the MEM/WB, PC-reload and flag results.
module mem_stage_ctrl #(
  parameter int MEM_AW = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       Data,
  input  logic [2:0]        WB_Address,
  input  logic              MR,
  input  logic              MW,
  input  logic              WB,
  input  logic [31:0]       Address,
  input  logic              Stack_PC,
  input  logic              Stack_Flags,
  input  logic [2:0]        Final_Flags,
  output logic              mem_req,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              stall,
  output logic              wb_en,
  output logic [2:0]        wb_addr,
  output logic [15:0]       wb_data,
  output logic              pc_load,
  output logic [31:0]       pc_value,
  output logic              flags_load,
  output logic [2:0]        Flags_From_Memory
);

  typedef enum logic {S_IDLE, S_ACCESS} state_e;

  typedef struct packed {
    logic              we;
    logic              spc;
    logic              sfl;
    logic              wb;
    logic [2:0]        wa;
    logic [2:0]        ff;
    logic [31:0]       data;
    logic [MEM_AW-1:0] base;
    logic [1:0]        last;
  } op_t;

  state_e      state_q, state_d;
  op_t         op_q, op_d;
  logic [1:0]  beat_q, beat_d;
  logic [15:0] lo_q, lo_d;
  logic [2:0]  flg_q, flg_d;
  logic        wb_en_q, wb_en_d;
  logic [2:0]  wb_addr_q, wb_addr_d;
  logic [15:0] wb_data_q, wb_data_d;
  logic        pc_load_q, pc_load_d;
  logic [31:0] pc_value_q, pc_value_d;
  logic        flags_load_q, flags_load_d;
  logic [2:0]  ffm_q, ffm_d;

  logic              mem_op, access, last_beat;
  logic              is_flag_beat, is_lo_beat;
  logic [MEM_AW-1:0] addr_off, beat_addr;
  logic [15:0]       beat_wdata, flags_word;
  logic              unused_addr_hi;

  assign unused_addr_hi = ^Address[31:MEM_AW];
  assign mem_op    = MR | MW;
  assign access    = (state_q == S_ACCESS);
  assign last_beat = (beat_q == op_q.last);

  // Pushes walk the stack downward, pops walk it upward, both from the latched base.
  always_comb begin
    addr_off   = MEM_AW'(beat_q);
    beat_addr  = op_q.we ? (op_q.base - addr_off) : (op_q.base + addr_off);
    flags_word = {13'b0, op_q.ff};
    if (op_q.spc) begin
      case (beat_q)
        2'd0:    beat_wdata = op_q.data[31:16];
        2'd1:    beat_wdata = op_q.data[15:0];
        default: beat_wdata = flags_word;
      endcase
    end else if (op_q.sfl) begin
      beat_wdata = flags_word;
    end else begin
      beat_wdata = op_q.data[15:0];
    end
    is_flag_beat = ~op_q.we & op_q.sfl & (~op_q.spc | (beat_q == 2'd0));
    is_lo_beat   = ~op_q.we & op_q.spc & (beat_q == (op_q.sfl ? 2'd1 : 2'd0));
  end

  assign mem_req   = access;
  assign mem_we    = access & op_q.we;
  assign mem_addr  = access ? beat_addr : '0;
  assign mem_wdata = access ? beat_wdata : '0;
  // Drops in the final-ack cycle so EX/MEM advances on that edge and the op is not re-issued.
  assign stall = ~reset & ((~access & mem_op) | (access & ~(mem_ack & last_beat)));

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    beat_d       = beat_q;
    lo_d         = lo_q;
    flg_d        = flg_q;
    wb_en_d      = wb_en_q;
    wb_addr_d    = wb_addr_q;
    wb_data_d    = wb_data_q;
    pc_load_d    = 1'b0;
    pc_value_d   = pc_value_q;
    flags_load_d = 1'b0;
    ffm_d        = ffm_q;
    case (state_q)
      S_IDLE: begin
        if (mem_op) begin
          op_d.we   = MW;
          op_d.spc  = Stack_PC;
          op_d.sfl  = Stack_Flags;
          op_d.wb   = WB;
          op_d.wa   = WB_Address;
          op_d.ff   = Final_Flags;
          op_d.data = Data;
          op_d.base = Address[MEM_AW-1:0];
          op_d.last = Stack_PC ? (Stack_Flags ? 2'd2 : 2'd1) : 2'd0;
          beat_d    = '0;
          wb_en_d   = 1'b0;
          state_d   = S_ACCESS;
        end else begin
          wb_en_d   = WB;
          wb_addr_d = WB_Address;
          wb_data_d = Data[15:0];
        end
      end
      S_ACCESS: begin
        wb_en_d = 1'b0;
        if (mem_ack) begin
          if (is_lo_beat)   lo_d  = mem_rdata;
          if (is_flag_beat) flg_d = mem_rdata[2:0];
          if (last_beat) begin
            state_d   = S_IDLE;
            beat_d    = '0;
            wb_addr_d = op_q.wa;
            if (op_q.we) begin
              wb_en_d   = op_q.wb;
              wb_data_d = op_q.data[15:0];
            end else if (op_q.spc) begin
              // Final beat of a PC pop is always the high half.
              pc_load_d  = 1'b1;
              pc_value_d = {mem_rdata, lo_q};
              if (op_q.sfl) begin
                flags_load_d = 1'b1;
                ffm_d        = flg_q;
              end
            end else if (op_q.sfl) begin
              flags_load_d = 1'b1;
              ffm_d        = mem_rdata[2:0];
            end else begin
              wb_en_d   = op_q.wb;
              wb_data_d = mem_rdata;
            end
          end else begin
            beat_d = beat_q + 2'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      op_q         <= '0;
      beat_q       <= '0;
      lo_q         <= '0;
      flg_q        <= '0;
      wb_en_q      <= 1'b0;
      wb_addr_q    <= '0;
      wb_data_q    <= '0;
      pc_load_q    <= 1'b0;
      pc_value_q   <= '0;
      flags_load_q <= 1'b0;
      ffm_q        <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      beat_q       <= beat_d;
      lo_q         <= lo_d;
      flg_q        <= flg_d;
      wb_en_q      <= wb_en_d;
      wb_addr_q    <= wb_addr_d;
      wb_data_q    <= wb_data_d;
      pc_load_q    <= pc_load_d;
      pc_value_q   <= pc_value_d;
      flags_load_q <= flags_load_d;
      ffm_q        <= ffm_d;
    end
  end

  assign wb_en             = wb_en_q;
  assign wb_addr           = wb_addr_q;
  assign wb_data           = wb_data_q;
  assign pc_load           = pc_load_q;
  assign pc_value          = pc_value_q;
  assign flags_load        = flags_load_q;
  assign Flags_From_Memory = ffm_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: a latency-programmable memory responder plus a
// transaction-level reference model of the beat plan and registered results.
module tb_mem_stage_ctrl;
  localparam int AW   = 12;
  localparam int MASK = (1 << AW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   Data, Address;
  logic [2:0]    WB_Address, Final_Flags;
  logic          MR, MW, WB, Stack_PC, Stack_Flags;
  logic          mem_req, mem_we, mem_ack;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata, mem_rdata;
  logic          stall, wb_en, pc_load, flags_load;
  logic [2:0]    wb_addr, Flags_From_Memory;
  logic [15:0]   wb_data;
  logic [31:0]   pc_value;

  mem_stage_ctrl #(.MEM_AW(AW)) dut (
    .clk(clk), .reset(reset), .Data(Data), .WB_Address(WB_Address), .MR(MR), .MW(MW),
    .WB(WB), .Address(Address), .Stack_PC(Stack_PC), .Stack_Flags(Stack_Flags),
    .Final_Flags(Final_Flags), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall(stall),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .pc_load(pc_load),
    .pc_value(pc_value), .flags_load(flags_load), .Flags_From_Memory(Flags_From_Memory)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit we;
    int addr;
    int data;
  } beat_t;

  int          tests = 0;
  int          fails = 0;
  int          lat = 0;
  int          cnt = 0;
  beat_t       got_q[$];
  logic [15:0] mem [0:MASK];
  logic [31:0] exp_pc = '0;
  logic [2:0]  exp_ffm = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Memory responder: ack after `lat` wait cycles per beat, junk rdata otherwise.
  initial begin
    beat_t b;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (mem_req) begin
        if (cnt == 0) begin
          mem_ack   = 1'b1;
          mem_rdata = mem[mem_addr];
        end else begin
          mem_ack   = 1'b0;
          mem_rdata = 16'($urandom);
          cnt--;
        end
      end else begin
        mem_ack   = 1'($urandom_range(0, 1));
        mem_rdata = 16'($urandom);
      end
      @(negedge clk);
      if (mem_req && mem_ack) begin
        b.we   = mem_we;
        b.addr = int'(mem_addr);
        b.data = int'(mem_wdata);
        got_q.push_back(b);
        if (mem_we) mem[mem_addr] = mem_wdata;
        cnt = lat;
      end
    end
  end

  task automatic idle_inputs();
    MR = 0; MW = 0; WB = 0; Stack_PC = 0; Stack_Flags = 0;
  endtask

  task automatic do_op(input string nm, input bit mr, input bit mw, input bit wb,
                       input bit sp, input bit sf, input logic [2:0] wa,
                       input logic [31:0] addr, input logic [31:0] data,
                       input logic [2:0] ff, input int l);
    beat_t exp_q[$];
    beat_t e;
    int    a, st, nb;
    bit    done, e_wb, e_pl, e_fl;
    logic [15:0] e_wd;
    a    = int'(addr) & MASK;
    e_wb = 0; e_pl = 0; e_fl = 0; e_wd = data[15:0];
    if (mw) begin
      e.we = 1;
      if (sp) begin
        e.addr = a;              e.data = int'(data[31:16]); exp_q.push_back(e);
        e.addr = (a - 1) & MASK; e.data = int'(data[15:0]);  exp_q.push_back(e);
        if (sf) begin e.addr = (a - 2) & MASK; e.data = int'(ff); exp_q.push_back(e); end
      end else begin
        e.addr = a; e.data = sf ? int'(ff) : int'(data[15:0]); exp_q.push_back(e);
      end
      e_wb = wb;
    end else if (mr) begin
      e.we = 0; e.data = 0;
      if (sp) begin
        int o;
        o = sf ? 1 : 0;
        if (sf) begin
          e.addr = a; exp_q.push_back(e);
          exp_ffm = mem[a][2:0];
          e_fl = 1;
        end
        e.addr = (a + o) & MASK;     exp_q.push_back(e);
        e.addr = (a + o + 1) & MASK; exp_q.push_back(e);
        exp_pc = {mem[(a + o + 1) & MASK], mem[(a + o) & MASK]};
        e_pl = 1;
      end else if (sf) begin
        e.addr = a; exp_q.push_back(e);
        exp_ffm = mem[a][2:0];
        e_fl = 1;
      end else begin
        e.addr = a; exp_q.push_back(e);
        e_wb = wb;
        e_wd = mem[a];
      end
    end else begin
      e_wb = wb;
    end
    nb = exp_q.size();

    got_q.delete();
    lat = l; cnt = l;
    @(posedge clk); #1;
    MR = mr; MW = mw; WB = wb; Stack_PC = sp; Stack_Flags = sf;
    WB_Address = wa; Address = addr; Data = data; Final_Flags = ff;
    st = 0; done = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (!stall) begin done = 1; break; end
      st++;
    end
    check({nm, ".done"}, 32'(done), 32'd1);
    @(posedge clk); #1;
    idle_inputs();
    check({nm, ".stall_cycles"}, st, nb * (l + 1));
    check({nm, ".nbeats"}, got_q.size(), nb);
    for (int i = 0; i < nb && i < got_q.size(); i++) begin
      check($sformatf("%s.b%0d.we", nm, i), 32'(got_q[i].we), 32'(exp_q[i].we));
      check($sformatf("%s.b%0d.addr", nm, i), got_q[i].addr, exp_q[i].addr);
      if (exp_q[i].we) check($sformatf("%s.b%0d.wdata", nm, i), got_q[i].data, exp_q[i].data);
    end
    check({nm, ".wb_en"}, 32'(wb_en), 32'(e_wb));
    if (e_wb) begin
      check({nm, ".wb_addr"}, 32'(wb_addr), 32'(wa));
      check({nm, ".wb_data"}, 32'(wb_data), 32'(e_wd));
    end
    check({nm, ".pc_load"}, 32'(pc_load), 32'(e_pl));
    check({nm, ".flags_load"}, 32'(flags_load), 32'(e_fl));
    check({nm, ".pc_value"}, pc_value, exp_pc);
    check({nm, ".ffm"}, 32'(Flags_From_Memory), 32'(exp_ffm));
    @(posedge clk); #1;
    check({nm, ".wb_en_1cyc"}, 32'(wb_en), 32'd0);
    check({nm, ".pc_load_1cyc"}, 32'(pc_load), 32'd0);
    check({nm, ".flags_load_1cyc"}, 32'(flags_load), 32'd0);
  endtask

  initial begin
    bit seen;
    for (int i = 0; i <= MASK; i++) mem[i] = 16'($urandom);
    reset = 1'b1;
    idle_inputs();
    Data = '0; Address = '0; WB_Address = '0; Final_Flags = '0;
    #1;
    check("rst.mem_req", 32'(mem_req), 0);
    check("rst.stall", 32'(stall), 0);
    check("rst.wb_en", 32'(wb_en), 0);
    check("rst.pc_load", 32'(pc_load), 0);
    check("rst.flags_load", 32'(flags_load), 0);
    check("rst.pc_value", pc_value, 0);
    check("rst.ffm", 32'(Flags_From_Memory), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    do_op("pass", 0, 0, 1, 0, 0, 3'd7, 32'h0, 32'd127, 3'd0, 0);
    mem[12'h020] = 16'hBEEF;
    do_op("load", 1, 0, 1, 0, 0, 3'd3, 32'h20, 32'h0, 3'd0, 4);
    do_op("call", 0, 1, 0, 1, 0, 3'd0, 32'h3FF, 32'h0001_0015, 3'd0, 0);
    check("call.mem3ff", 32'(mem[12'h3FF]), 32'h0001);
    check("call.mem3fe", 32'(mem[12'h3FE]), 32'h0015);
    mem[12'h3FD] = 16'h0005;
    do_op("rti", 1, 0, 0, 1, 1, 3'd0, 32'h3FD, 32'h0, 3'd0, 2);
    check("rti.pc_const", pc_value, 32'h0001_0015);
    check("rti.ffm_const", 32'(Flags_From_Memory), 32'b101);
    do_op("wrap", 0, 1, 1, 1, 1, 3'd2, 32'h0, 32'hCAFE_1234, 3'b010, 1);
    check("wrap.memffe", 32'(mem[12'hFFE]), 32'h0002);
    do_op("both", 1, 1, 1, 0, 0, 3'd5, 32'h1234_5ABC, 32'h0000_7777, 3'd0, 1);
    do_op("flagpop", 1, 0, 1, 0, 1, 3'd1, 32'h0000_0ABC, 32'h0, 3'd0, 0);

    // Reset during the second beat of a 3-beat push.
    got_q.delete();
    lat = 2; cnt = 2;
    @(posedge clk); #1;
    MW = 1; Stack_PC = 1; Stack_Flags = 1; WB = 1; Address = 32'h100;
    Data = 32'h1111_2222; Final_Flags = 3'b111;
    seen = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (got_q.size() == 1) begin seen = 1; break; end
    end
    check("abort.reached_beat2", 32'(seen), 1);
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check("abort.mem_req", 32'(mem_req), 0);
    check("abort.stall", 32'(stall), 0);
    check("abort.wb_en", 32'(wb_en), 0);
    check("abort.pc_load", 32'(pc_load), 0);
    check("abort.flags_load", 32'(flags_load), 0);
    idle_inputs();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("abort.nbeats", got_q.size(), 1);
    exp_pc = '0; exp_ffm = '0;
    do_op("after_rst", 0, 0, 1, 0, 0, 3'd4, 32'h0, 32'h0000_0042, 3'd0, 0);

    for (int k = 0; k < 40; k++) begin
      do_op($sformatf("rnd%0d", k), 1'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom), 3'($urandom), $urandom, $urandom,
            3'($urandom), int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
